// File: rtl/pit8253_pkg.sv
// Shared definitions for the pit8253 bus initiator: counter modes,
// read/load encodings, FSM states and control-word packing.
package pit8253_pkg;

   localparam logic [2:0] M0 = 3'd0;
   localparam logic [2:0] M1 = 3'd1;
   localparam logic [2:0] M2 = 3'd2;
   localparam logic [2:0] M3 = 3'd3;
   localparam logic [2:0] M4 = 3'd4;
   localparam logic [2:0] M5 = 3'd5;

   localparam logic [1:0] RL_LATCH = 2'b00;
   localparam logic [1:0] RL_LSB   = 2'b01;
   localparam logic [1:0] RL_MSB   = 2'b10;
   localparam logic [1:0] RL_WORD  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CW,
      ST_WR_LO,
      ST_WR_HI,
      ST_RD_LO,
      ST_RD_HI,
      ST_DONE,
      ST_REJ
   } state_t;

   // 8253 control word layout: SC1 SC0 RL1 RL0 M2 M1 M0 BCD
   function automatic logic [7:0] cw_pack(input logic [1:0] ch, input logic [1:0] rl,
                                          input logic [2:0] mode, input logic bcd);
      return {ch, rl, mode, bcd};
   endfunction

endpackage

// File: rtl/pit8253_ce_gap.sv
// Gap counter: turns the I/O clock enable into a bus_slot strobe, holding
// off GAP_CE enabled cycles after every bus cycle.
module pit8253_ce_gap #(
   parameter int unsigned GAP_CE = 0
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_ce,
   input  logic i_clr,
   input  logic i_fire,
   output logic o_bus_slot
);

   logic [3:0] r_gap;

   assign o_bus_slot = i_ce & (r_gap == '0);

   // Reload on each bus cycle, then count down on ce-qualified clocks only.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clr) begin
         r_gap <= '0;
      end else if (i_fire) begin
         r_gap <= 4'(GAP_CE);
      end else if (i_ce && (r_gap != '0)) begin
         r_gap <= r_gap - 4'd1;
      end
   end

endmodule

// File: rtl/pit8253_bus_master.sv
// Bus initiator for the pit8253 CPU port: expands program / read-back
// commands into ordered control-word, count-write and count-read cycles.
module pit8253_bus_master
   import pit8253_pkg::*;
#(
   parameter int unsigned GAP_CE      = 0,
   parameter logic [1:0]  PIT_BASE_CW = 2'b11
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_ce,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic        i_cmd_op,
   input  logic [1:0]  i_cmd_ch,
   input  logic [1:0]  i_cmd_rl,
   input  logic [2:0]  i_cmd_mode,
   input  logic        i_cmd_bcd,
   input  logic [15:0] i_cmd_value,
   output logic        o_rsp_valid,
   output logic [15:0] o_rsp_data,
   output logic        o_rsp_err,
   output logic        o_busy,
   output logic [1:0]  o_pit_a,
   output logic        o_pit_wr,
   output logic        o_pit_rd,
   output logic [7:0]  o_pit_dout,
   input  logic [7:0]  i_pit_din
);

   state_t      r_state, w_next;
   logic        r_op, r_bcd;
   logic [1:0]  r_ch, r_rl;
   logic [2:0]  r_mode;
   logic [15:0] r_value, r_rsp_data;
   logic [7:0]  r_lo, r_pit_dout, w_dout;
   logic [1:0]  r_pit_a, w_a;
   logic        w_wr, w_rd, w_slot, w_raw_slot, w_accept, w_reject;

   assign w_accept = (r_state == ST_IDLE) & i_cmd_valid;
   assign w_reject = (i_cmd_ch == 2'd3) | (~i_cmd_op & (i_cmd_rl == RL_LATCH));
   // Strobes drop as soon as reset is seen so a reset cycle never issues a bus cycle.
   assign w_slot   = w_raw_slot & ~i_reset;

   pit8253_ce_gap #(.GAP_CE(GAP_CE)) u_gap (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_ce       (i_ce),
      .i_clr      (w_accept),
      .i_fire     (w_wr | w_rd),
      .o_bus_slot (w_raw_slot)
   );

   // Next-state and bus-cycle decode; address/data hold unless a strobe fires.
   always_comb begin
      w_next = r_state;
      w_wr   = 1'b0;
      w_rd   = 1'b0;
      w_a    = r_pit_a;
      w_dout = r_pit_dout;
      case (r_state)
         ST_IDLE:  if (i_cmd_valid) w_next = w_reject ? ST_REJ : ST_CW;
         ST_CW: if (w_slot) begin
            w_wr   = 1'b1;
            w_a    = PIT_BASE_CW;
            w_dout = r_op ? cw_pack(r_ch, RL_LATCH, 3'd0, 1'b0)
                          : cw_pack(r_ch, r_rl, r_mode, r_bcd);
            w_next = r_op ? ST_RD_LO : ((r_rl == RL_MSB) ? ST_WR_HI : ST_WR_LO);
         end
         ST_WR_LO: if (w_slot) begin
            w_wr   = 1'b1;
            w_a    = r_ch;
            w_dout = r_value[7:0];
            w_next = (r_rl == RL_WORD) ? ST_WR_HI : ST_DONE;
         end
         ST_WR_HI: if (w_slot) begin
            w_wr   = 1'b1;
            w_a    = r_ch;
            w_dout = r_value[15:8];
            w_next = ST_DONE;
         end
         ST_RD_LO: if (w_slot) begin
            w_rd   = 1'b1;
            w_a    = r_ch;
            w_next = ST_RD_HI;
         end
         ST_RD_HI: if (w_slot) begin
            w_rd   = 1'b1;
            w_a    = r_ch;
            w_next = ST_DONE;
         end
         ST_DONE:  w_next = ST_IDLE;
         ST_REJ:   w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // State, command latch, held bus address/data and read-back capture.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_op       <= 1'b0;
         r_ch       <= '0;
         r_rl       <= '0;
         r_mode     <= '0;
         r_bcd      <= 1'b0;
         r_value    <= '0;
         r_lo       <= '0;
         r_rsp_data <= '0;
         r_pit_a    <= '0;
         r_pit_dout <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_op    <= i_cmd_op;
            r_ch    <= i_cmd_ch;
            r_rl    <= i_cmd_rl;
            r_mode  <= i_cmd_mode;
            r_bcd   <= i_cmd_bcd;
            r_value <= i_cmd_value;
         end
         if (w_wr | w_rd) begin
            r_pit_a    <= w_a;
            r_pit_dout <= w_dout;
         end
         // LSB is staged so the visible response only changes when the full count lands.
         if (w_rd && (r_state == ST_RD_LO)) r_lo <= i_pit_din;
         if (w_rd && (r_state == ST_RD_HI)) r_rsp_data <= {i_pit_din, r_lo};
      end
   end

   assign o_cmd_ready = (r_state == ST_IDLE);
   assign o_busy      = ~o_cmd_ready;
   assign o_rsp_valid = (r_state == ST_REJ) | ((r_state == ST_DONE) & r_op);
   assign o_rsp_err   = (r_state == ST_REJ);
   assign o_rsp_data  = (r_state == ST_REJ) ? '0 : r_rsp_data;
   assign o_pit_a     = w_a;
   assign o_pit_dout  = w_dout;
   assign o_pit_wr    = w_wr;
   assign o_pit_rd    = w_rd;

endmodule

// File: tb/tb_pit8253_bus_master.sv
// Directed bench for pit8253_bus_master: a GAP_CE=0 instance against a
// small 8253 counter/latch model, plus a GAP_CE=3 instance for spacing.
module tb_pit8253_bus_master;
   import pit8253_pkg::*;

   logic        clk = 1'b0, reset = 1'b1, ce = 1'b1, ce_div2 = 1'b0;
   logic        v0 = 1'b0, v1 = 1'b0, op = 1'b0, bcd = 1'b0;
   logic [1:0]  ch = '0, rl = '0;
   logic [2:0]  mode = '0;
   logic [15:0] val = '0;
   logic [7:0]  din;

   logic        ready, busy, rsp_valid, rsp_err, wr, rd;
   logic [15:0] rsp_data;
   logic [1:0]  a;
   logic [7:0]  dout;
   logic        g_ready, g_busy, g_rsp_valid, g_rsp_err, g_wr, g_rd;
   logic [15:0] g_rsp_data;
   logic [1:0]  g_a;
   logic [7:0]  g_dout;

   pit8253_bus_master #(.GAP_CE(0), .PIT_BASE_CW(2'b11)) dut (
      .i_clk(clk), .i_reset(reset), .i_ce(ce), .i_cmd_valid(v0), .o_cmd_ready(ready),
      .i_cmd_op(op), .i_cmd_ch(ch), .i_cmd_rl(rl), .i_cmd_mode(mode), .i_cmd_bcd(bcd),
      .i_cmd_value(val), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
      .o_busy(busy), .o_pit_a(a), .o_pit_wr(wr), .o_pit_rd(rd), .o_pit_dout(dout), .i_pit_din(din));

   pit8253_bus_master #(.GAP_CE(3), .PIT_BASE_CW(2'b11)) dut_g (
      .i_clk(clk), .i_reset(reset), .i_ce(ce), .i_cmd_valid(v1), .o_cmd_ready(g_ready),
      .i_cmd_op(op), .i_cmd_ch(ch), .i_cmd_rl(rl), .i_cmd_mode(mode), .i_cmd_bcd(bcd),
      .i_cmd_value(val), .o_rsp_valid(g_rsp_valid), .o_rsp_data(g_rsp_data), .o_rsp_err(g_rsp_err),
      .o_busy(g_busy), .o_pit_a(g_a), .o_pit_wr(g_wr), .o_pit_rd(g_rd), .o_pit_dout(g_dout), .i_pit_din(din));

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned n_vec = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ce is either stuck high or toggles every clock.
   initial forever begin
      @(posedge clk); #1;
      ce = ce_div2 ? ~ce : 1'b1;
   end

   // Minimal 8253 channel-1 model: down-counter on ce, latch command, LSB/MSB read toggle.
   logic [15:0] m_cnt = 16'h0400, m_latch = '0;
   logic        m_rdi = 1'b0, m_load = 1'b0;
   assign din = m_rdi ? m_latch[15:8] : m_latch[7:0];
   always @(posedge clk) begin
      if (m_load) m_cnt <= 16'h0400;
      else if (ce) m_cnt <= m_cnt - 16'd1;
      if (wr && a == 2'b11 && dout[7:6] == 2'b01 && dout[5:4] == 2'b00) begin
         m_latch <= m_cnt;
         m_rdi   <= 1'b0;
      end else if (rd) begin
         m_rdi <= ~m_rdi;
      end
   end

   typedef struct {bit rd; logic [1:0] a; logic [7:0] d; int unsigned c;} bus_t;
   bus_t        bq[$];
   int unsigned gq[$];
   int unsigned rsp_n = 0, rsp_c = 0;
   logic [15:0] rsp_d = '0;
   logic        rsp_e = 1'b0;

   // Bus monitor sampled mid-cycle.
   always @(negedge clk) begin
      if (wr | rd) begin
         chk("strobe_ce", {31'd0, ce}, 32'd1);
         chk("wr_rd_excl", {31'd0, wr & rd}, 32'd0);
         bq.push_back('{rd, a, dout, cyc});
      end
      if (g_wr | g_rd) begin
         chk("g_strobe_ce", {31'd0, ce}, 32'd1);
         gq.push_back(cyc);
      end
      if (rsp_valid) begin
         rsp_n++;
         rsp_c = cyc;
         rsp_d = rsp_data;
         rsp_e = rsp_err;
      end
   end

   int unsigned acc = 0;

   task automatic send(input bit g, input logic o, input logic [1:0] c, input logic [1:0] r,
                       input logic [2:0] m, input logic [15:0] value);
      @(posedge clk); #1;
      op = o; ch = c; rl = r; mode = m; bcd = 1'b0; val = value;
      if (g) v1 = 1'b1; else v0 = 1'b1;
      @(posedge clk); #1;
      v0 = 1'b0; v1 = 1'b0;
      acc = cyc;
   endtask

   // n counts clocks from the accepting edge until ready is seen again.
   task automatic wait_ready(input bit g, output int unsigned n);
      n = 1;
      while (!(g ? g_ready : ready) && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic do_readback(input string tag);
      int unsigned n, r0;
      m_load = 1'b1;
      @(posedge clk); #1;
      m_load = 1'b0;
      r0 = rsp_n;
      bq.delete();
      send(1'b0, 1'b1, 2'd1, RL_LATCH, M0, 16'h0000);
      wait_ready(1'b0, n);
      chk({tag, "_rsp_n"}, rsp_n - r0, 1);
      chk({tag, "_err"}, {31'd0, rsp_e}, 0);
      chk({tag, "_data"}, {16'd0, rsp_d}, {16'd0, m_latch});
      chk({tag, "_range"}, {31'd0, (rsp_d <= 16'h0400) && (rsp_d > 16'h03E0)}, 1);
      chk({tag, "_nbus"}, bq.size(), 3);
      if (bq.size() == 3) begin
         chk({tag, "_cw"}, {bq[0].rd, bq[0].a, bq[0].d}, {1'b0, 2'd3, 8'h40});
         chk({tag, "_rd0"}, {bq[1].rd, bq[1].a}, {1'b1, 2'd1});
         chk({tag, "_rd1"}, {bq[2].rd, bq[2].a}, {1'b1, 2'd1});
      end
   endtask

   initial begin
      int unsigned n, r0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, ready}, 1);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 0);
      chk("rst_rsp_data", {16'd0, rsp_data}, 0);
      chk("rst_wr_rd", {30'd0, wr, rd}, 0);
      chk("rst_a_dout", {22'd0, a, dout}, 0);
      reset = 1'b0;

      // Program ch2 M3 LSB+MSB 0x1234, back to back.
      r0 = rsp_n;
      bq.delete();
      send(1'b0, 1'b0, 2'd2, RL_WORD, M3, 16'h1234);
      wait_ready(1'b0, n);
      chk("t1_latency", n, 5);
      chk("t1_nbus", bq.size(), 3);
      chk("t1_rsp", rsp_n - r0, 0);
      if (bq.size() == 3) begin
         chk("t1_w0", {bq[0].rd, bq[0].a, bq[0].d}, {1'b0, 2'd3, 8'hB6});
         chk("t1_w1", {bq[1].rd, bq[1].a, bq[1].d}, {1'b0, 2'd2, 8'h34});
         chk("t1_w2", {bq[2].rd, bq[2].a, bq[2].d}, {1'b0, 2'd2, 8'h12});
         chk("t1_first", bq[0].c, acc);
         chk("t1_b2b", bq[2].c - bq[0].c, 2);
      end

      // Program ch0 M0 LSB only: two writes, no response.
      r0 = rsp_n;
      bq.delete();
      send(1'b0, 1'b0, 2'd0, RL_LSB, M0, 16'hAB55);
      wait_ready(1'b0, n);
      chk("t2_nbus", bq.size(), 2);
      chk("t2_rsp", rsp_n - r0, 0);
      if (bq.size() == 2) begin
         chk("t2_w0", {bq[0].rd, bq[0].a, bq[0].d}, {1'b0, 2'd3, 8'h10});
         chk("t2_w1", {bq[1].rd, bq[1].a, bq[1].d}, {1'b0, 2'd0, 8'h55});
      end

      // Read back ch1 with ce on every second clock.
      ce_div2 = 1'b1;
      do_readback("t3");
      ce_div2 = 1'b0;
      @(posedge clk); #1;

      // Rejects: illegal channel, then program with rl=00.
      r0 = rsp_n;
      bq.delete();
      send(1'b0, 1'b0, 2'd3, RL_WORD, M0, 16'h5555);
      wait_ready(1'b0, n);
      chk("t4a_rsp", rsp_n - r0, 1);
      chk("t4a_err", {31'd0, rsp_e}, 1);
      chk("t4a_data", {16'd0, rsp_d}, 0);
      chk("t4a_lat", rsp_c - acc + 1, 1);
      chk("t4a_nbus", bq.size(), 0);
      r0 = rsp_n;
      send(1'b0, 1'b0, 2'd1, RL_LATCH, M2, 16'h1111);
      wait_ready(1'b0, n);
      chk("t4b_rsp", rsp_n - r0, 1);
      chk("t4b_err", {31'd0, rsp_e}, 1);
      chk("t4b_lat", rsp_c - acc + 1, 1);
      chk("t4b_nbus", bq.size(), 0);
      chk("t4b_ready", n, 2);

      // GAP_CE=3 instance: three idle ce cycles between strobes.
      gq.delete();
      send(1'b1, 1'b0, 2'd2, RL_WORD, M3, 16'h1234);
      wait_ready(1'b1, n);
      chk("t5_nbus", gq.size(), 3);
      chk("t5_latency", n, 11);
      if (gq.size() == 3) begin
         chk("t5_first", gq[0], acc);
         chk("t5_gap01", gq[1] - gq[0], 4);
         chk("t5_gap12", gq[2] - gq[1], 4);
      end

      // Reset right after the control-word write drops the command.
      r0 = rsp_n;
      bq.delete();
      send(1'b0, 1'b0, 2'd2, RL_WORD, M3, 16'h1234);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("t6_ready", {31'd0, ready}, 1);
      chk("t6_nbus", bq.size(), 1);
      chk("t6_rsp", rsp_n - r0, 0);
      do_readback("t6rb");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/pit8253_bus_master.md
Name: pit8253_bus_master

Overview:
- Bus initiator for the pit8253 timer's CPU-side port.
- Turns single high-level commands into correctly ordered 8253 bus cycles, each aligned to the I/O clock enable:
  - "program channel" → control-word write, then count write(s).
  - "read back channel" → counter-latch write, then LSB and MSB reads.
- Sits between the sound/firmware sequencer and the timer, replacing ad-hoc CPU I/O sequences.

Parameters:
- GAP_CE, 0: idle ce strobes inserted between consecutive bus cycles (0..15).
- PIT_BASE_CW, 2'b11: pit_a value that addresses the control-word register.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  I/O bus clock enable; all PIT bus cycles complete on clk edges with ce=1.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid & cmd_ready.
- cmd_op  in  1  0 = program, 1 = read back.
- cmd_ch  in  2  channel 0..2; 3 is illegal.
- cmd_rl  in  2  read/load mode for program: 01 LSB, 10 MSB, 11 LSB then MSB.
- cmd_mode  in  3  counter mode M0..M5.
- cmd_bcd  in  1  BCD bit.
- cmd_value  in  16  count value for program.
- rsp_valid  out  1  one-cycle pulse: readback done or command rejected.
- rsp_data  out  16  latched count {MSB, LSB}.
- rsp_err  out  1  qualifies rsp_valid: command rejected.
- busy  out  1  inverse of cmd_ready.
- pit_a  out  2  PIT address.
- pit_wr  out  1  PIT write strobe.
- pit_rd  out  1  PIT read strobe.
- pit_dout  out  8  data to PIT.
- pit_din  in  8  data from PIT (combinational read mux).

Behaviour:
- Reset values: cmd_ready=1, busy=0, rsp_valid=0, rsp_err=0, rsp_data=0, pit_wr=0, pit_rd=0, pit_a=0, pit_dout=0, gap counter=0, state IDLE.
- Accept: on cmd_valid & cmd_ready, latch all cmd_* fields. Command fields are ignored while busy.
- Reject rule: cmd_ch=3, or program with cmd_rl=00. Next cycle: rsp_valid=1, rsp_err=1, rsp_data=0. No bus activity. Return to IDLE.
- Bus-cycle rule:
  - A strobe is asserted only in a cycle where ce=1, for exactly that one cycle.
  - pit_a and pit_dout are driven valid in that same cycle.
  - pit_wr and pit_rd are never both high.
  - Strobes are 0 in all other cycles; pit_a and pit_dout hold their last value.
  - The state advances on that edge.
- Control word byte: {cmd_ch, rl, cmd_mode, cmd_bcd}.
  - rl = cmd_rl for program.
  - rl = 2'b00 (counter latch) for readback; mode and bcd bits are 0 for readback.
- States:
  - IDLE → CW on accept.
  - CW: write at pit_a=PIT_BASE_CW.
    - Program: → WR_LO if rl ∈ {01, 11}; → WR_HI if rl=10.
    - Readback: → RD_LO.
  - WR_LO: write cmd_value[7:0] at pit_a=cmd_ch. → WR_HI if rl=11, else DONE.
  - WR_HI: write cmd_value[15:8] at pit_a=cmd_ch. → DONE.
  - RD_LO: pit_rd at pit_a=cmd_ch; capture pit_din into rsp_data[7:0] on that edge. → RD_HI.
  - RD_HI: same as RD_LO, capture into rsp_data[15:8]. → DONE.
  - DONE: one cycle. rsp_valid=1 for readback only (rsp_err=0); program completes silently. → IDLE.
- Gap: between consecutive bus cycles of one command, wait GAP_CE ce strobes (count ce=1 cycles only).
  - GAP_CE=0 with ce stuck high gives back-to-back cycles on consecutive clocks.
  - Minimum latency with ce=1 and GAP_CE=0: program rl=11 accept→IDLE is 5 clocks; readback accept→rsp_valid is 4 clocks.
- ce low: state and outputs freeze, except rsp_valid, which is a pulse and self-clears.
- Reset mid-command: strobes deassert on the next edge, the command is dropped, no rsp_valid. A partially written PIT count is left as is.
- rsp_data holds its value until the next readback completes or reset.

Decomposition:
- Shared package pit8253_pkg holds:
  - mode constants M0..M5.
  - RL encodings RL_LATCH=00, RL_LSB=01, RL_MSB=10, RL_WORD=11.
  - state enumeration.
  - control-word packing function.
- One natural sub-module: pit8253_ce_gap, the gap counter that qualifies ce into a bus_slot strobe.
- Everything else stays in the top FSM.

Test Plan:
- Program ch2, M3, rl=11, value 16'h1234, ce=1, GAP_CE=0 → writes in order: (a=3, 8'hB6), (a=2, 8'h34), (a=2, 8'h12), one per clock; cmd_ready back high 5 clocks after accept.
- Program ch0, M0, rl=01, value 16'hAB55 → exactly two writes: (a=3, 8'h10), (a=0, 8'h55). No rsp_valid.
- Readback ch1 against a pit8253 instance counting from 16'h0400, ce every 2nd clock → write (a=3, 8'h40), then two reads at a=1 on ce cycles; rsp_valid with rsp_data equal to the count at latch time; rsp_err=0.
- cmd_ch=3, or program with rl=00 → rsp_valid & rsp_err one cycle after accept, rsp_data=0, no strobes.
- GAP_CE=3, ce every clock, rl=11 program → exactly 3 idle ce cycles between each strobe; strobes only on ce=1 cycles (checker assertion).
- Assert reset in the cycle after the CW write of a rl=11 program → no further strobes; cmd_ready=1 on the next clock; a following readback completes normally.
